// File: rtl/hetic_pkg.sv
// hetic_pkg: register map, field positions and line state shared by the interrupt controller
package hetic_pkg;
    localparam logic [31:0] CtrlOff  = 32'h000;
    localparam logic [31:0] ClaimOff = 32'h004;
    localparam logic [31:0] LineBase = 32'h800;
    localparam int GieBit   = 0;
    localparam int ThrLsb   = 8;
    localparam int ValidBit = 31;
    localparam int IeBit    = 0;
    localparam int IpBit    = 1;
    localparam int TrigLsb  = 2;
    localparam int HetiBit  = 4;
    localparam int NestBit  = 5;
    localparam int PrioLsb  = 8;

    // prio is sized for the largest supported priority count and masked on write
    typedef struct packed {
        logic [7:0] prio;
        logic       nest;
        logic       heti;
        logic [1:0] trig;
        logic       ip;
        logic       ie;
    } irq_line_t;

    function automatic logic [31:0] line_word(irq_line_t l);
        return {16'h0, l.prio, 2'b00, l.nest, l.heti, l.trig, l.ip, l.ie};
    endfunction
endpackage

// File: rtl/obi_bus.sv
// OBI_BUS: minimal OBI request/response bundle; rid is carried but unused by this design
interface OBI_BUS;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        rid;
    modport Manager     (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err, rid);
    modport Subordinate (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err, rid);
endinterface

// File: rtl/hetic_gateway.sv
// hetic_gateway: per-line synchroniser, edge history and polarity handling
//   irq_i  raw asynchronous sources      edge_i 1 = edge triggered
//   low_i  1 = active-low / falling      set_o  request to set ip this cycle
module hetic_gateway #(
    parameter int NrLines      = 64,
    parameter int NrSyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrLines-1:0] irq_i,
    input  logic [NrLines-1:0] edge_i,
    input  logic [NrLines-1:0] low_i,
    output logic [NrLines-1:0] set_o
);
    logic [NrLines-1:0] sync, prev_q, prev_d, act, act_prev;

    generate
        if (NrSyncStages == 0) begin : g_bypass
            assign sync = irq_i;
        end else begin : g_sync
            logic [NrSyncStages-1:0][NrLines-1:0] stage_q, stage_d;
            always_comb begin
                stage_d[0] = irq_i;
                for (int j = 1; j < NrSyncStages; j++) stage_d[j] = stage_q[j-1];
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) stage_q <= '0;
                else       stage_q <= stage_d;
            end
            assign sync = stage_q[NrSyncStages-1];
        end
    endgenerate

    always_comb prev_d = sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= prev_d;
    end

    // normalise polarity so both modes look active-high; an edge is active now but not before
    assign act      = sync ^ low_i;
    assign act_prev = prev_q ^ low_i;
    assign set_o    = act & ~(edge_i & act_prev);
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: picks the valid line with the highest priority, lowest index on ties
//   valid_i/prio_i per-line request and priority; found_o/id_o/prio_o winner
module irq_arbiter #(
    parameter  int NrLines   = 64,
    parameter  int PrioWidth = 5,
    localparam int IdWidth   = $clog2(NrLines)
) (
    input  logic [NrLines-1:0]                valid_i,
    input  logic [NrLines-1:0][PrioWidth-1:0] prio_i,
    output logic                              found_o,
    output logic [IdWidth-1:0]                id_o,
    output logic [PrioWidth-1:0]              prio_o
);
    // strict greater-than keeps the earlier (lower) index on equal priority
    always_comb begin
        found_o = 1'b0;
        id_o    = '0;
        prio_o  = '0;
        for (int i = 0; i < NrLines; i++) begin
            if (valid_i[i] && (!found_o || prio_i[i] > prio_o)) begin
                found_o = 1'b1;
                id_o    = IdWidth'(i);
                prio_o  = prio_i[i];
            end
        end
    end
endmodule

// File: rtl/obi_hetic_pro.sv
// obi_hetic_pro: OBI-mapped interrupt controller with per-line trigger, priority and threshold
//   obi_sbr    register bus (CTRL, CLAIM, LINE[i])
//   ext_irqs_i asynchronous sources; irq_*_o winning interrupt; irq_ack_i/irq_id_i claim
module obi_hetic_pro
    import hetic_pkg::*;
#(
    parameter  int NrIrqLines   = 64,
    parameter  int NrIrqPrios   = 32,
    parameter  int NrSyncStages = 2,
    parameter  int ArbPipeline  = 0,
    localparam int IrqWidth     = $clog2(NrIrqLines),
    localparam int PrioWidth    = $clog2(NrIrqPrios)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    OBI_BUS.Subordinate           obi_sbr,
    input  logic [NrIrqLines-1:0] ext_irqs_i,
    output logic                  irq_valid_o,
    output logic [IrqWidth-1:0]   irq_id_o,
    output logic [PrioWidth-1:0]  irq_level_o,
    output logic                  irq_heti_o,
    output logic                  irq_nest_o,
    input  logic                  irq_ack_i,
    input  logic [IrqWidth-1:0]   irq_id_i
);
    localparam logic [7:0] PrioMask = 8'(NrIrqPrios - 1);

    irq_line_t lines_q [NrIrqLines];
    irq_line_t lines_d [NrIrqLines];
    logic                 gie_q, gie_d, rvalid_q, rvalid_d, err_q, err_d;
    logic [PrioWidth-1:0] thr_q, thr_d;
    logic [31:0]          rdata_q, rdata_d, line_off;
    logic                 is_ctrl, is_claim, is_line, wr;
    logic [IrqWidth-1:0]  lidx;
    logic [NrIrqLines-1:0] set, edge_v, low_v, valid_v;
    logic [NrIrqLines-1:0][PrioWidth-1:0] prio_v;
    logic                 win_found, win_ok;
    logic [IrqWidth-1:0]  win_id;
    logic [PrioWidth-1:0] win_prio;
    logic [IrqWidth+PrioWidth+2:0] arb_d;
    logic                 unused_bits;

    assign unused_bits = ^{obi_sbr.wdata[31:16], obi_sbr.wdata[7:6], obi_sbr.be[3:2]};

    assign line_off = obi_sbr.addr - LineBase;
    assign is_ctrl  = obi_sbr.addr == CtrlOff;
    assign is_claim = obi_sbr.addr == ClaimOff;
    assign is_line  = obi_sbr.addr >= LineBase && line_off[1:0] == 2'b00 && (line_off >> 2) < 32'(NrIrqLines);
    assign lidx     = line_off[IrqWidth+1:2];
    assign wr       = obi_sbr.req & obi_sbr.we;

    always_comb begin
        for (int i = 0; i < NrIrqLines; i++) begin
            edge_v[i]  = lines_q[i].trig[0];
            low_v[i]   = lines_q[i].trig[1];
            valid_v[i] = lines_q[i].ie & lines_q[i].ip;
            prio_v[i]  = lines_q[i].prio[PrioWidth-1:0];
        end
    end

    hetic_gateway #(.NrLines(NrIrqLines), .NrSyncStages(NrSyncStages)) u_gw (
        .clk_i(clk_i), .rst_i(rst_i), .irq_i(ext_irqs_i), .edge_i(edge_v), .low_i(low_v), .set_o(set)
    );

    irq_arbiter #(.NrLines(NrIrqLines), .PrioWidth(PrioWidth)) u_arb (
        .valid_i(valid_v), .prio_i(prio_v), .found_o(win_found), .id_o(win_id), .prio_o(win_prio)
    );

    // later assignments win: bus write, then ack clear, then gateway set
    always_comb begin
        lines_d = lines_q;
        gie_d   = gie_q;
        thr_d   = thr_q;
        if (wr && is_ctrl) begin
            if (obi_sbr.be[0]) gie_d = obi_sbr.wdata[GieBit];
            if (obi_sbr.be[1]) thr_d = obi_sbr.wdata[ThrLsb +: PrioWidth];
        end
        if (wr && is_line) begin
            if (obi_sbr.be[0]) begin
                lines_d[lidx].ie   = obi_sbr.wdata[IeBit];
                lines_d[lidx].ip   = obi_sbr.wdata[IpBit];
                lines_d[lidx].trig = obi_sbr.wdata[TrigLsb +: 2];
                lines_d[lidx].heti = obi_sbr.wdata[HetiBit];
                lines_d[lidx].nest = obi_sbr.wdata[NestBit];
            end
            if (obi_sbr.be[1]) lines_d[lidx].prio = obi_sbr.wdata[PrioLsb +: 8] & PrioMask;
        end
        if (irq_ack_i && 32'(irq_id_i) < 32'(NrIrqLines)) lines_d[irq_id_i].ip = 1'b0;
        for (int i = 0; i < NrIrqLines; i++) if (set[i]) lines_d[i].ip = 1'b1;
    end

    always_comb begin
        win_ok = gie_q & win_found & (win_prio > thr_q);
        arb_d  = win_ok ? {1'b1, win_id, win_prio, lines_q[win_id].heti, lines_q[win_id].nest} : '0;
    end

    generate
        if (ArbPipeline != 0) begin : g_pipe
            logic [IrqWidth+PrioWidth+2:0] arb_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) arb_q <= '0;
                else       arb_q <= arb_d;
            end
            assign {irq_valid_o, irq_id_o, irq_level_o, irq_heti_o, irq_nest_o} = arb_q;
        end else begin : g_comb
            assign {irq_valid_o, irq_id_o, irq_level_o, irq_heti_o, irq_nest_o} = arb_d;
        end
    endgenerate

    always_comb begin
        rvalid_d = obi_sbr.req;
        err_d    = obi_sbr.req & ~(is_ctrl | is_claim | is_line);
        rdata_d  = !obi_sbr.req ? '0 :
                   is_ctrl  ? (32'(thr_q) << ThrLsb) | (32'(gie_q) << GieBit) :
                   is_claim ? (32'(irq_valid_o) << ValidBit) | 32'(irq_id_o) :
                   is_line  ? line_word(lines_q[lidx]) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lines_q  <= '{default: '0};
            gie_q    <= 1'b0;
            thr_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            lines_q  <= lines_d;
            gie_q    <= gie_d;
            thr_q    <= thr_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // gnt is masked so nothing is accepted while reset is held
    assign obi_sbr.gnt    = obi_sbr.req & ~rst_i;
    assign obi_sbr.rvalid = rvalid_q;
    assign obi_sbr.rdata  = rdata_q;
    assign obi_sbr.err    = err_q;
    assign obi_sbr.rid    = 1'b0;
endmodule

// File: tb/tb_obi_hetic_pro.sv
// tb_obi_hetic_pro: directed and randomized checks of obi_hetic_pro against a behavioural model
module tb_obi_hetic_pro;
    localparam int N  = 64;
    localparam int NP = 32;
    localparam int S  = 2;
    localparam int IW = 6;
    localparam int PW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  ext_irqs_i = '0;
    logic          irq_valid_o, irq_heti_o, irq_nest_o;
    logic [IW-1:0] irq_id_o;
    logic [PW-1:0] irq_level_o;
    logic          irq_ack_i = 1'b0;
    logic [IW-1:0] irq_id_i = '0;

    OBI_BUS bus ();

    obi_hetic_pro dut (
        .clk_i(clk_i), .rst_i(rst_i), .obi_sbr(bus), .ext_irqs_i(ext_irqs_i),
        .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_level_o(irq_level_o),
        .irq_heti_o(irq_heti_o), .irq_nest_o(irq_nest_o), .irq_ack_i(irq_ack_i), .irq_id_i(irq_id_i)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // behavioural model: line fields as plain arrays, inputs as a history of raw samples
    bit           m_ie [N];
    bit           m_ip [N];
    bit           m_heti [N];
    bit           m_nest [N];
    bit [1:0]     m_trig [N];
    int           m_prio [N];
    bit           m_gie;
    int           m_thr;
    logic [N-1:0] h [S+2];
    bit           e_rv, e_err;
    logic [31:0]  e_rd;

    function automatic void m_win(output bit v, output int id, output int lv);
        int best = -1;
        id = 0;
        for (int i = 0; i < N; i++)
            if (m_ie[i] && m_ip[i] && m_prio[i] > best) begin
                best = m_prio[i];
                id = i;
            end
        v = m_gie && best > m_thr;
        if (!v) id = 0;
        lv = v ? best : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_ie[i] = 0; m_ip[i] = 0; m_heti[i] = 0; m_nest[i] = 0; m_trig[i] = 0; m_prio[i] = 0;
        end
        for (int j = 0; j < S + 2; j++) h[j] = '0;
        m_gie = 0; m_thr = 0; e_rv = 0; e_rd = 0; e_err = 0;
    endtask

    task automatic m_step();
        bit v, hi;
        int id, lv, li;
        logic s, p;
        bit [N-1:0] setv;
        logic [31:0] a, w;
        m_win(v, id, lv);
        h[0] = ext_irqs_i;
        for (int i = 0; i < N; i++) begin
            s  = h[S][i];
            p  = h[S+1][i];
            hi = !m_trig[i][1];
            setv[i] = m_trig[i][0] ? (hi ? (s && !p) : (p && !s)) : (s == hi);
        end
        e_rv = bus.req; e_rd = 0; e_err = 0;
        if (bus.req) begin
            a = bus.addr;
            w = bus.wdata;
            if (a == 0) begin
                e_rd = 32'(m_thr * 256 + int'(m_gie));
                if (bus.we && bus.be[0]) m_gie = w[0];
                if (bus.we && bus.be[1]) m_thr = int'(w[15:8]) % NP;
            end else if (a == 4) begin
                e_rd = {v, 31'(id)};
            end else if (a >= 32'h800 && a < 32'h800 + 4 * N && a % 4 == 0) begin
                li = int'((a - 32'h800) / 4);
                e_rd = 32'(m_prio[li] * 256 + int'(m_nest[li]) * 32 + int'(m_heti[li]) * 16
                          + int'(m_trig[li]) * 4 + int'(m_ip[li]) * 2 + int'(m_ie[li]));
                if (bus.we && bus.be[0]) begin
                    m_ie[li] = w[0]; m_ip[li] = w[1]; m_trig[li] = w[3:2]; m_heti[li] = w[4]; m_nest[li] = w[5];
                end
                if (bus.we && bus.be[1]) m_prio[li] = int'(w[15:8]) % NP;
            end else begin
                e_err = 1;
            end
        end
        if (irq_ack_i && int'(irq_id_i) < N) m_ip[irq_id_i] = 0;
        for (int i = 0; i < N; i++) if (setv[i]) m_ip[i] = 1;
        for (int j = S + 1; j >= 1; j--) h[j] = h[j-1];
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) m_reset();
            else m_step();
        end
    end

    initial begin
        bit v;
        int id, lv;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                m_win(v, id, lv);
                check("valid", 32'(irq_valid_o), 32'(v));
                check("id", 32'(irq_id_o), id);
                check("level", 32'(irq_level_o), lv);
                check("heti", 32'(irq_heti_o), v ? 32'(m_heti[id]) : 0);
                check("nest", 32'(irq_nest_o), v ? 32'(m_nest[id]) : 0);
                check("gnt", 32'(bus.gnt), 32'(bus.req));
                check("rid", 32'(bus.rid), 0);
                check("rvalid", 32'(bus.rvalid), 32'(e_rv));
                if (e_rv) begin
                    check("rdata", bus.rdata, e_rd);
                    check("err", 32'(bus.err), 32'(e_err));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, want $finish");
        $fatal(1);
    end

    function automatic logic [31:0] la(input int i);
        return 32'h800 + 32'(4 * i);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.req = 1; bus.we = 1; bus.addr = a; bus.be = be; bus.wdata = d;
        tick();
        bus.req = 0; bus.we = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        bus.req = 1; bus.we = 0; bus.addr = a; bus.be = 4'hf;
        tick();
        bus.req = 0;
        d = bus.rdata;
        e = bus.err;
    endtask

    task automatic do_reset();
        rst_i = 1; ext_irqs_i = '0; irq_ack_i = 0; bus.req = 0;
        repeat (2) tick();
        rst_i = 0;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        int k;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.be = 0; bus.wdata = 0;
        do_reset();
        check("rst_valid", 32'(irq_valid_o), 0);
        rd(32'h0, d, e);
        check("rst_ctrl", d, 0);
        rd(la(5), d, e);
        check("rst_line5", d, 0);

        // edge on line 5 reaches the outputs after sync stages plus one
        wr(32'h0, 4'hf, 32'h1);
        wr(la(5), 4'hf, 32'h0705);
        ext_irqs_i[5] = 1'b1;
        tick(); tick();
        check("lat_early", 32'(irq_valid_o), 0);
        tick();
        check("lat_valid", 32'(irq_valid_o), 1);
        check("lat_id", 32'(irq_id_o), 5);
        check("lat_level", 32'(irq_level_o), 7);
        irq_ack_i = 1; irq_id_i = 5;
        tick();
        irq_ack_i = 0;
        check("ack_clears", 32'(irq_valid_o), 0);

        // tie to lowest index, then priority raise switches winner
        do_reset();
        wr(32'h0, 4'hf, 32'h1);
        wr(la(3), 4'hf, 32'h0403);
        wr(la(9), 4'hf, 32'h0403);
        check("tie_id", 32'(irq_id_o), 3);
        wr(la(9), 4'b0010, 32'h0500);
        check("prio_id", 32'(irq_id_o), 9);

        // threshold is strictly exceeded
        wr(la(9), 4'b0010, 32'h0700);
        wr(32'h0, 4'b0010, 32'h0700);
        check("thr7_valid", 32'(irq_valid_o), 0);
        wr(32'h0, 4'b0010, 32'h0600);
        check("thr6_valid", 32'(irq_valid_o), 1);
        rd(32'h4, d, e);
        check("claim", d, 32'h8000_0009);
        wr(32'h4, 4'hf, 32'h0);
        check("claim_wr_err", 32'(bus.err), 0);

        // byte enables and decode errors
        wr(la(1), 4'b0010, 32'hffff_ffff);
        rd(la(1), d, e);
        check("be_prio_only", d, 32'h0000_1f00);
        rd(la(N), d, e);
        check("oor_err", 32'(e), 1);
        check("oor_rdata", d, 0);
        rd(32'h10, d, e);
        check("hole_err", 32'(e), 1);

        // gateway set beats ack on the same line in the same cycle
        do_reset();
        wr(32'h0, 4'hf, 32'h1);
        wr(la(2), 4'hf, 32'h0505);
        ext_irqs_i[2] = 1'b1;
        repeat (3) tick();
        check("edge2_id", 32'(irq_id_o), 2);
        ext_irqs_i[2] = 1'b0;
        repeat (3) tick();
        ext_irqs_i[2] = 1'b1;
        tick(); tick();
        irq_ack_i = 1; irq_id_i = 2;
        tick();
        irq_ack_i = 0;
        rd(la(2), d, e);
        check("ack_vs_edge_ip", 32'(d[1]), 1);
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
        rd(la(2), d, e);
        check("ack_only_ip", 32'(d[1]), 0);
        wr(la(4), 4'hf, 32'h0301);
        ext_irqs_i[4] = 1'b1;
        repeat (3) tick();
        irq_ack_i = 1; irq_id_i = 4;
        tick();
        irq_ack_i = 0;
        rd(la(4), d, e);
        check("level_reassert_ip", 32'(d[1]), 1);

        // reset in the middle of a read
        do_reset();
        wr(32'h0, 4'hf, 32'h1);
        wr(la(6), 4'hf, 32'h0201);
        ext_irqs_i[6] = 1'b1;
        repeat (3) tick();
        check("pre_rst_valid", 32'(irq_valid_o), 1);
        bus.req = 1; bus.we = 0; bus.addr = la(6);
        #2;
        rst_i = 1; bus.req = 0; ext_irqs_i = '0;
        #1;
        check("rst_out_valid", 32'(irq_valid_o), 0);
        check("rst_out_id", 32'(irq_id_o), 0);
        check("rst_out_level", 32'(irq_level_o), 0);
        check("rst_out_gnt", 32'(bus.gnt), 0);
        check("rst_out_rvalid", 32'(bus.rvalid), 0);
        check("rst_out_rdata", bus.rdata, 0);
        repeat (2) tick();
        rst_i = 0;
        tick();
        check("post_rst_rvalid", 32'(bus.rvalid), 0);
        rd(32'h0, d, e);
        check("post_rst_ctrl", d, 0);
        rd(la(6), d, e);
        check("post_rst_line6", d, 0);
        rd(32'h4, d, e);
        check("post_rst_claim", d, 0);

        // randomized traffic on the low lines
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, 15);
                ext_irqs_i[k] = ~ext_irqs_i[k];
            end
            bus.req   = 1'($urandom_range(0, 1));
            bus.we    = 1'($urandom_range(0, 1));
            bus.be    = 4'($urandom);
            bus.wdata = $urandom;
            case ($urandom_range(0, 9))
                0: bus.addr = 32'h0;
                1: bus.addr = 32'h4;
                2: bus.addr = la(N);
                3: bus.addr = 32'h800 + 32'($urandom_range(0, 63)) * 2 + 1;
                default: bus.addr = la($urandom_range(0, 15));
            endcase
            irq_ack_i = $urandom_range(0, 7) == 0;
            irq_id_i  = IW'($urandom_range(0, 15));
            tick();
        end
        bus.req = 0; irq_ack_i = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
